// File: rtl/i2c_reg_seq_if.sv
// Request/response and byte-master handshake bundle for i2c_reg_seq.
// The slave modport is the sequencer's view; master is the surrounding environment's.
interface i2c_reg_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_read;
  logic       req_hs;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic [2:0] resp_err;
  logic       cmd_active;
  logic       cmd_high_speed;
  logic       cmd_read;
  logic       read_nack;
  logic [6:0] cmd_addr;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_ready;
  logic [7:0] data_out;
  logic       addr_err;
  logic       data_err;

  modport slave (
    input  req_valid, req_read, req_hs, req_dev, req_reg, req_wdata,
    input  data_ready, data_out, addr_err, data_err,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output cmd_active, cmd_high_speed, cmd_read, read_nack, cmd_addr, data_valid, data_in
  );

  modport master (
    output req_valid, req_read, req_hs, req_dev, req_reg, req_wdata,
    output data_ready, data_out, addr_err, data_err,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  cmd_active, cmd_high_speed, cmd_read, read_nack, cmd_addr, data_valid, data_in
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// Single-byte I2C register write/read sequencer in front of the byte master; one request in flight.
// Write ~2 byte times + STOP_WAIT + 2 cycles, read adds a second phase; req_ready is high only when idle.
module i2c_reg_seq #(
  parameter int STOP_WAIT = 2048,
  parameter int TIMEOUT   = 65535
) (
  input  logic         clk,
  input  logic         reset,
  i2c_reg_seq_if.slave bus
);
  typedef enum logic [2:0] {POST_RST, IDLE, W_REG, W_DATA, R_BYTE, STOP, DONE} state_t;

  localparam int CMAX = (STOP_WAIT > TIMEOUT) ? STOP_WAIT : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_WAIT - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lat_read, lat_read_nxt;
  logic [7:0]    lat_wdata, lat_wdata_nxt;
  logic          pending_read, pending_read_nxt;
  logic [2:0]    err, err_nxt;

  logic          cmd_active_q, cmd_active_nxt;
  logic          cmd_hs_q, cmd_hs_nxt;
  logic          cmd_read_q, cmd_read_nxt;
  logic          read_nack_q, read_nack_nxt;
  logic [6:0]    cmd_addr_q, cmd_addr_nxt;
  logic          data_valid_q, data_valid_nxt;
  logic [7:0]    data_in_q, data_in_nxt;
  logic          resp_valid_q, resp_valid_nxt;
  logic [7:0]    resp_rdata_q, resp_rdata_nxt;
  logic [2:0]    resp_err_q, resp_err_nxt;

  logic          byte_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= POST_RST;
      cnt          <= '0;
      lat_read     <= 1'b0;
      lat_wdata    <= '0;
      pending_read <= 1'b0;
      err          <= '0;
      cmd_active_q <= 1'b0;
      cmd_hs_q     <= 1'b0;
      cmd_read_q   <= 1'b0;
      read_nack_q  <= 1'b0;
      cmd_addr_q   <= '0;
      data_valid_q <= 1'b0;
      data_in_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      lat_read     <= lat_read_nxt;
      lat_wdata    <= lat_wdata_nxt;
      pending_read <= pending_read_nxt;
      err          <= err_nxt;
      cmd_active_q <= cmd_active_nxt;
      cmd_hs_q     <= cmd_hs_nxt;
      cmd_read_q   <= cmd_read_nxt;
      read_nack_q  <= read_nack_nxt;
      cmd_addr_q   <= cmd_addr_nxt;
      data_valid_q <= data_valid_nxt;
      data_in_q    <= data_in_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_rdata_q <= resp_rdata_nxt;
      resp_err_q   <= resp_err_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt + CW'(1);
    lat_read_nxt     = lat_read;
    lat_wdata_nxt    = lat_wdata;
    pending_read_nxt = pending_read;
    err_nxt          = err;
    cmd_active_nxt   = cmd_active_q;
    cmd_hs_nxt       = cmd_hs_q;
    cmd_read_nxt     = cmd_read_q;
    read_nack_nxt    = read_nack_q;
    cmd_addr_nxt     = cmd_addr_q;
    data_valid_nxt   = data_valid_q;
    data_in_nxt      = data_in_q;
    resp_valid_nxt   = 1'b0;
    resp_rdata_nxt   = resp_rdata_q;
    resp_err_nxt     = resp_err_q;
    // data NACK only counts while we are the transmitter
    byte_err         = bus.addr_err | (bus.data_err & (state != R_BYTE));

    case (state)
      POST_RST: begin
        if (cnt == STOP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      IDLE: begin
        cnt_nxt = '0;
        if (bus.req_valid) begin
          lat_read_nxt     = bus.req_read;
          lat_wdata_nxt    = bus.req_wdata;
          pending_read_nxt = 1'b0;
          err_nxt          = '0;
          cmd_active_nxt   = 1'b1;
          cmd_read_nxt     = 1'b0;
          cmd_addr_nxt     = bus.req_dev;
          cmd_hs_nxt       = bus.req_hs;
          data_valid_nxt   = 1'b1;
          data_in_nxt      = bus.req_reg;
          state_nxt        = W_REG;
        end
      end
      W_REG, W_DATA, R_BYTE: begin
        if (bus.data_ready) begin
          cnt_nxt    = '0;
          err_nxt[0] = err[0] | bus.addr_err;
          err_nxt[1] = err[1] | (bus.data_err & (state != R_BYTE));
          if (state == R_BYTE) resp_rdata_nxt = bus.data_out;
          if (state == W_REG && !byte_err && !lat_read) begin
            data_in_nxt = lat_wdata;
            state_nxt   = W_DATA;
          end else begin
            cmd_active_nxt = 1'b0;
            data_valid_nxt = 1'b0;
            read_nack_nxt  = 1'b0;
            state_nxt      = STOP;
            if (state == W_REG && !byte_err) pending_read_nxt = 1'b1;
          end
        end else if (cnt == TO_LAST) begin
          cnt_nxt        = '0;
          err_nxt[2]     = 1'b1;
          cmd_active_nxt = 1'b0;
          data_valid_nxt = 1'b0;
          read_nack_nxt  = 1'b0;
          state_nxt      = STOP;
        end
      end
      STOP: begin
        if (cnt == STOP_LAST) begin
          cnt_nxt = '0;
          if (pending_read && err == 3'b000) begin
            pending_read_nxt = 1'b0;
            cmd_active_nxt   = 1'b1;
            cmd_read_nxt     = 1'b1;
            read_nack_nxt    = 1'b1;
            data_valid_nxt   = 1'b1;
            state_nxt        = R_BYTE;
          end else begin
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = err;
            state_nxt      = DONE;
          end
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = POST_RST;
      end
    endcase
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.cmd_active     = cmd_active_q;
  assign bus.cmd_high_speed = cmd_hs_q;
  assign bus.cmd_read       = cmd_read_q;
  assign bus.read_nack      = read_nack_q;
  assign bus.cmd_addr       = cmd_addr_q;
  assign bus.data_valid     = data_valid_q;
  assign bus.data_in        = data_in_q;
endmodule

// File: tb/tb_i2c_reg_seq.sv
// Randomized bench for i2c_reg_seq: a byte-master model answers the handshake, and
// expected bytes/flags/read data come from the register-transaction rules.
module tb_i2c_reg_seq;
  localparam int SW     = 20;
  localparam int TO     = 100;
  localparam int BUDGET = 3*SW + 3*TO + 200;

  logic clk = 1'b0;
  logic reset;

  i2c_reg_seq_if bus();

  i2c_reg_seq #(.STOP_WAIT(SW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scenario knobs read by the master model
  int         absent    = 0;
  int         nack_idx  = -1;
  int         stall_idx = 99;
  logic [7:0] rval      = 8'h00;
  logic [7:0] model_rdata = 8'h00;
  logic [17:0] log_q[$];
  int         last_gap  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte master model: answers each presented byte after a random delay
  initial begin : master_model
    int idx;
    int wc;
    logic ae, de;
    idx = 0;
    bus.data_ready = 1'b0;
    bus.data_out   = 8'h00;
    bus.addr_err   = 1'b0;
    bus.data_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.cmd_active) idx = 0;
      else if (bus.data_valid && idx < stall_idx) begin
        wc = $urandom_range(3, 0);
        repeat (wc) @(negedge clk);
        if (bus.cmd_active && bus.data_valid) begin
          ae = (idx == 0) && (absent != 0);
          de = !bus.cmd_read && (idx == nack_idx);
          log_q.push_back({bus.cmd_high_speed, bus.cmd_addr, bus.cmd_read, bus.read_nack,
                           bus.cmd_read ? 8'h00 : bus.data_in});
          bus.data_out   = bus.cmd_read ? rval : 8'($urandom);
          bus.addr_err   = ae;
          bus.data_err   = de;
          bus.data_ready = 1'b1;
          @(negedge clk);
          bus.data_ready = 1'b0;
          bus.addr_err   = 1'b0;
          bus.data_err   = 1'b0;
          if (ae || de) chk("abort_drop", {30'd0, bus.cmd_active, bus.data_valid}, 32'd0);
          idx++;
        end
      end
    end
  end

  // length of the most recent cmd_active-low run that ended in a new START
  initial begin : gap_mon
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_active) begin
        if (run > 0) last_gap = run;
        run = 0;
      end else begin
        run++;
      end
    end
  end

  task automatic post_reset_check();
    int hi;
    hi = 0;
    for (int i = 0; i < SW-1; i++) begin
      @(negedge clk);
      if (bus.req_ready) hi++;
    end
    chk("post_rst_guard", hi, 0);
    @(negedge clk);
    chk("post_rst_ready", bus.req_ready, 1);
  endtask

  task automatic issue(input logic rd, input logic hs, input logic [6:0] dev,
                       input logic [7:0] rg, input logic [7:0] wd);
    int c;
    c = 0;
    while (!bus.req_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("req_ready_idle", bus.req_ready, 1);
    log_q.delete();
    bus.req_valid = 1'b1;
    bus.req_read  = rd;
    bus.req_hs    = hs;
    bus.req_dev   = dev;
    bus.req_reg   = rg;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_hs    = 1'($urandom);
    bus.req_dev   = 7'($urandom);
    bus.req_reg   = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    chk("accept_ready_low", bus.req_ready, 0);
    chk("accept_cmd", {bus.cmd_active, bus.data_valid, bus.cmd_read, bus.cmd_high_speed, bus.cmd_addr, bus.data_in},
        {1'b1, 1'b1, 1'b0, hs, dev, rg});
  endtask

  task automatic do_req(input logic rd, input logic hs, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input int ab, input int nk, input int st, input logic [7:0] rv);
    logic [17:0] exp_q[$];
    logic [17:0] got;
    logic [2:0]  exp_err;
    int c, rdy_hi, n;
    absent = ab; nack_idx = nk; stall_idx = st; rval = rv;

    exp_err = 3'b000;
    if (st == 0) exp_err = 3'b100;
    else begin
      exp_q.push_back({hs, dev, 2'b00, rg});
      if (ab != 0)      exp_err = 3'b001;
      else if (nk == 0) exp_err = 3'b010;
      else if (rd) begin
        exp_q.push_back({hs, dev, 2'b11, 8'h00});
        model_rdata = rv;
      end else if (st == 1) exp_err = 3'b100;
      else begin
        exp_q.push_back({hs, dev, 2'b00, wd});
        if (nk == 1) exp_err = 3'b010;
      end
    end

    issue(rd, hs, dev, rg, wd);
    rdy_hi = 0;
    c = 0;
    while (!bus.resp_valid && c < BUDGET) begin
      if (bus.req_ready) rdy_hi++;
      @(negedge clk);
      c++;
    end
    chk("resp_seen", bus.resp_valid, 1);
    chk("resp_err", bus.resp_err, exp_err);
    chk("resp_rdata", bus.resp_rdata, model_rdata);
    chk("ready_low_busy", rdy_hi, 0);
    chk("byte_count", log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      got = log_q[i];
      chk("byte_seen", got, exp_q[i]);
    end
    if (st == 0) chk("timeout_latency", (c >= TO+SW-1 && c <= TO+SW+2), 1);
    if (rd && exp_err == 3'b000) chk("stop_gap", last_gap, SW);
    @(negedge clk);
    chk("resp_pulse_1cyc", bus.resp_valid, 0);
    chk("ready_after_resp", bus.req_ready, 1);
  endtask

  task automatic reset_mid_write();
    int c;
    absent = 0; nack_idx = -1; stall_idx = 1;
    issue(1'b0, 1'b0, 7'h22, 8'h10, 8'h55);
    c = 0;
    while (!(log_q.size() == 1 && !bus.data_ready) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("w_data_reached", {bus.cmd_active, bus.data_valid, bus.data_in}, {2'b11, 8'h55});
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_cmd", {bus.cmd_active, bus.data_valid, bus.cmd_read, bus.read_nack, bus.cmd_high_speed}, 0);
    chk("arst_data", {bus.cmd_addr, bus.data_in}, 0);
    chk("arst_resp", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata}, 0);
    model_rdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    post_reset_check();
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_read  = 1'b0;
    bus.req_hs    = 1'b0;
    bus.req_dev   = 7'h00;
    bus.req_reg   = 8'h00;
    bus.req_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_rdata}, 0);
    chk("rst_cmd", {bus.cmd_active, bus.cmd_high_speed, bus.cmd_read, bus.read_nack, bus.cmd_addr}, 0);
    chk("rst_data", {bus.data_valid, bus.data_in}, 0);
    @(negedge clk);
    reset = 1'b0;
    post_reset_check();

    do_req(1'b0, 1'b0, 7'h39, 8'h41, 8'h10, 0, -1, 99, 8'h00);
    do_req(1'b1, 1'b0, 7'h1A, 8'h05, 8'h00, 0, -1, 99, 8'hA7);
    do_req(1'b0, 1'b0, 7'h50, 8'h00, 8'h12, 1, -1, 99, 8'h00);
    do_req(1'b0, 1'b1, 7'h2C, 8'h07, 8'h33, 0,  1, 99, 8'h00);
    do_req(1'b1, 1'b0, 7'h2C, 8'h08, 8'h00, 0,  0, 99, 8'hEE);
    do_req(1'b0, 1'b0, 7'h11, 8'h22, 8'h33, 0, -1,  0, 8'h00);
    reset_mid_write();
    do_req(1'b0, 1'b1, 7'h39, 8'h42, 8'h5A, 0, -1, 99, 8'h00);

    for (int i = 0; i < 24; i++) begin
      logic rd;
      int sc, ab, nk, st;
      rd = 1'($urandom);
      sc = $urandom_range(9, 0);
      ab = 0; nk = -1; st = 99;
      if (sc == 6)      ab = 1;
      else if (sc == 7) nk = 0;
      else if (sc == 8) nk = rd ? 0 : 1;
      else if (sc == 9) st = rd ? 0 : $urandom_range(1, 0);
      do_req(rd, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), ab, nk, st, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
